video_lcd_blit: RTL
===================

# video_lcd_blit

Upstream sequencer for the ILI9341 4-wire SPI byte engine. A CPU programs a pixel window and a start bit. The block then drives the SPI engine's register port as a bus master through a fixed sequence: CS low, CASET, PASET, RAMWR, then two bytes per RGB565 pixel taken from a valid/ready stream, then CS high. This frees the CPU from per-byte polling during framebuffer pushes.

## Interface
Parameters:
- MAX_PIXELS, 76800: upper bound on window area; sizes the 17-bit pixel counter.

Ports (clock, reset first):
- i_clock  in  1  system clock; the SPI engine runs on the same clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_request  in  1  CPU register access request.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  2  register index: 0 = XWIN {x1[31:16], x0[15:0]}; 1 = YWIN {y1, y0}; 2 = CTRL (write: bit0 start, bit1 abort; read: {29'b0, error, done, busy}); 3 = COUNT (read: pixels remaining, 17 bits).
- i_wdata  in  32  CPU write data.
- o_rdata  out  32  CPU read data; valid when o_ready is high.
- o_ready  out  1  CPU access complete. One-cycle pulse, registered.
- o_lcd_request  out  1  request to the SPI engine.
- o_lcd_address  out  2  0 = command byte, 1 = data byte, 2 = CS control (wdata[0] = cs_n).
- o_lcd_wdata  out  32  byte in [7:0], zeros above.
- i_lcd_ready  in  1  SPI engine completion.
- i_pixel_valid  in  1  pixel stream valid.
- i_pixel  in  16  RGB565 pixel.
- o_pixel_ready  out  1  pixel consumed this cycle.

o_lcd_rw is not a port. The engine's rw is tied to 1 at the parent: this block only writes.

## Operation
- CPU side:
  - Every access completes 1 cycle after i_request rises; o_ready pulses for 1 cycle.
  - Writes to XWIN and YWIN while busy are ignored but still acked.
  - Start while busy is ignored.
  - Start with x1 < x0 or y1 < y0 sets error and does not go busy.
  - A valid start clears done and error, loads COUNT = (x1-x0+1)*(y1-y0+1) (17-bit), and sets busy.
- Byte transaction sub-handshake, used for every engine access:
  - ISSUE: hold o_lcd_request high with stable o_lcd_address and o_lcd_wdata until i_lcd_ready is sampled high.
  - RELEASE: drive o_lcd_request low for exactly 1 cycle. The engine returns to idle only after request drops.
  - Then advance.
- Main FSM states and transitions:
  - IDLE -> CSLO on a valid start. CSLO issues addr 2, wdata 0.
  - CSLO -> CMD_CA: byte 0x2A at addr 0.
  - CMD_CA -> DAT_CA: 4 bytes at addr 1: x0[15:8], x0[7:0], x1[15:8], x1[7:0]. A 2-bit index counts the bytes.
  - DAT_CA -> CMD_PA: 0x2B.
  - CMD_PA -> DAT_PA: y0 and y1 bytes, same order as DAT_CA.
  - DAT_PA -> CMD_RW: 0x2C.
  - CMD_RW -> PIX_WAIT.
  - PIX_WAIT: when i_pixel_valid is high, pulse o_pixel_ready for 1 cycle, latch the pixel, and go to PIX_HI.
  - PIX_HI: issue pixel[15:8].
  - PIX_LO: issue pixel[7:0], then decrement COUNT.
  - After PIX_LO: if COUNT == 0, go to CSHI; otherwise go to PIX_WAIT.
  - CSHI: issue addr 2, wdata 1.
  - CSHI -> IDLE: clear busy, set done.
- Abort: sets a sticky flag. On completion of the current byte transaction, the FSM goes to CSHI and sets done. COUNT keeps its remaining value. Abort in IDLE is a no-op.
- Pixels are never accepted outside PIX_WAIT. o_pixel_ready is combinationally independent of i_pixel_valid except in that state.

## Timing
- Reset: all outputs 0. o_lcd_wdata = 0. State IDLE. COUNT, windows, and status flags are 0.
- Reset mid-transfer: o_lcd_request drops immediately. CS is left as last driven by the engine, so software must re-init.
- Start-to-first-request latency: 1 cycle after the CTRL write ack.
- Minimum per-byte overhead above engine latency: 1 RELEASE cycle plus 1 cycle to re-assert request.
- An empty pixel stream stalls indefinitely in PIX_WAIT with o_lcd_request low.
- Single-pixel window (x0 = x1, y0 = y1): COUNT = 1, exactly 2 data bytes follow 0x2C.

## Test plan
- Window x 0..1, y 0..0, start, stream pixels 0xF800 and 0x07E0. Required engine byte log: CS0, C2A, D00 D00 D00 D01, C2B, D00 D00 D00 D00, C2C, DF8 D00 D07 DE0, CS1. Then done = 1, busy = 0, COUNT = 0.
- x0 = 5, x1 = 4, start. Required: error = 1, busy = 0, and no o_lcd_request activity.
- Full 320x240 window with a ready-after-3-cycles engine model. Required: COUNT starts at 76800 (0x12C00), 153600 pixel bytes are issued, and RELEASE is observed to be 1 cycle after each i_lcd_ready.
- Abort after 10 pixels. Required: the in-flight byte completes, then CS1 is issued, done = 1, COUNT = window area - 10, and no further o_pixel_ready pulses.
- i_pixel_valid held low for 50 cycles in PIX_WAIT. Required: o_lcd_request stays low and COUNT is unchanged. When valid rises, o_pixel_ready pulses for exactly 1 cycle.
- Assert i_reset_n low during DAT_PA with request high. Required: o_lcd_request = 0 asynchronously, status reads 0, and a new start runs the full sequence.

Source files
------------

// File: rtl/video_lcd_blit.sv
// Window blit sequencer for an ILI9341 SPI byte engine: emits CS low, CASET, PASET, RAMWR,
// two bytes per RGB565 pixel from a valid/ready stream, then CS high.
module video_lcd_blit #(
  parameter int unsigned MAX_PIXELS = 76800
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [1:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_lcd_request,
  output logic [1:0]  o_lcd_address,
  output logic [31:0] o_lcd_wdata,
  input  logic        i_lcd_ready,
  input  logic        i_pixel_valid,
  input  logic [15:0] i_pixel,
  output logic        o_pixel_ready
);
  localparam int unsigned CW = $clog2(MAX_PIXELS + 1);

  typedef enum logic [3:0] {
    StIdle, StCsLo, StCmdCa, StDatCa, StCmdPa, StDatPa, StCmdRw,
    StPixWait, StPixHi, StPixLo, StCsHi
  } state_e;

  state_e        r_state, w_next;
  logic [31:0]   r_xwin, r_ywin, r_rdata;
  logic          r_ready, r_go, r_done, r_error, r_abort, r_rel;
  logic [1:0]    r_idx;
  logic [15:0]   r_pixel;
  logic [CW-1:0] r_count;

  logic          w_acc, w_wr, w_ctrl_wr, w_busy, w_start, w_win_ok, w_is_byte, w_adv, w_take;
  logic [CW-1:0] w_width, w_height, w_area;
  logic [31:0]   w_win, w_rd_mux;
  logic [7:0]    w_dat_byte, w_lcd_byte;
  logic [1:0]    w_lcd_addr;

  // An access held high across its ack is taken only once.
  assign w_acc     = i_request & ~r_ready;
  assign w_wr      = w_acc & i_rw;
  assign w_ctrl_wr = w_wr & (i_address == 2'd2);
  assign w_busy    = r_go | (r_state != StIdle);
  assign w_start   = w_ctrl_wr & i_wdata[0] & ~w_busy;
  assign w_win_ok  = (r_xwin[31:16] >= r_xwin[15:0]) && (r_ywin[31:16] >= r_ywin[15:0]);
  assign w_width   = CW'(r_xwin[31:16]) - CW'(r_xwin[15:0]) + CW'(1);
  assign w_height  = CW'(r_ywin[31:16]) - CW'(r_ywin[15:0]) + CW'(1);
  assign w_area    = w_width * w_height;
  assign w_adv     = w_is_byte & r_rel;
  assign w_take    = (r_state == StPixWait) & ~r_abort & i_pixel_valid;

  always_comb begin
    w_rd_mux = 32'h0;
    unique case (i_address)
      2'd0: w_rd_mux = r_xwin;
      2'd1: w_rd_mux = r_ywin;
      2'd2: w_rd_mux = {29'h0, r_error, r_done, w_busy};
      2'd3: w_rd_mux = 32'(r_count);
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
      r_xwin  <= 32'h0;
      r_ywin  <= 32'h0;
      r_go    <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_abort <= 1'b0;
      r_count <= '0;
    end else begin
      r_ready <= w_acc;
      if (w_acc) r_rdata <= w_rd_mux;
      r_go <= w_start & w_win_ok;
      if (w_wr && !w_busy && i_address == 2'd0) r_xwin <= i_wdata;
      if (w_wr && !w_busy && i_address == 2'd1) r_ywin <= i_wdata;
      if (w_start) begin
        if (w_win_ok) begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_count <= w_area;
        end else begin
          r_error <= 1'b1;
        end
      end
      if (w_ctrl_wr && i_wdata[1] && w_busy) r_abort <= 1'b1;
      if (w_adv && r_state == StPixLo) r_count <= r_count - CW'(1);
      if (w_adv && r_state == StCsHi) begin
        r_done  <= 1'b1;
        r_abort <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= StIdle;
    else            r_state <= w_next;
  end

  // Each byte: request until the engine acks, then one low cycle so the engine can idle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rel   <= 1'b0;
      r_idx   <= 2'd0;
      r_pixel <= 16'h0;
    end else begin
      if (w_is_byte && !r_rel && i_lcd_ready) r_rel <= 1'b1;
      else if (r_rel)                         r_rel <= 1'b0;
      if (w_adv) r_idx <= (w_next == r_state) ? r_idx + 2'd1 : 2'd0;
      if (w_take) r_pixel <= i_pixel;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StIdle:    if (r_go) w_next = StCsLo;
      StPixWait: begin
        if (r_abort)            w_next = StCsHi;
        else if (i_pixel_valid) w_next = StPixHi;
      end
      default: begin
        if (w_adv) begin
          if (r_state == StCsHi)  w_next = StIdle;
          else if (r_abort)       w_next = StCsHi;
          else begin
            case (r_state)
              StCsLo:  w_next = StCmdCa;
              StCmdCa: w_next = StDatCa;
              StDatCa: w_next = (r_idx == 2'd3) ? StCmdPa : StDatCa;
              StCmdPa: w_next = StDatPa;
              StDatPa: w_next = (r_idx == 2'd3) ? StCmdRw : StDatPa;
              StCmdRw: w_next = StPixWait;
              StPixHi: w_next = StPixLo;
              StPixLo: w_next = (r_count <= CW'(1)) ? StCsHi : StPixWait;
              default: w_next = StIdle;
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    w_win      = (r_state == StDatPa) ? r_ywin : r_xwin;
    w_dat_byte = 8'h00;
    unique case (r_idx)
      2'd0: w_dat_byte = w_win[15:8];
      2'd1: w_dat_byte = w_win[7:0];
      2'd2: w_dat_byte = w_win[31:24];
      2'd3: w_dat_byte = w_win[23:16];
    endcase
    w_is_byte  = 1'b1;
    w_lcd_addr = 2'd0;
    w_lcd_byte = 8'h00;
    case (r_state)
      StCsLo:  w_lcd_addr = 2'd2;
      StCmdCa: w_lcd_byte = 8'h2A;
      StCmdPa: w_lcd_byte = 8'h2B;
      StCmdRw: w_lcd_byte = 8'h2C;
      StDatCa, StDatPa: begin
        w_lcd_addr = 2'd1;
        w_lcd_byte = w_dat_byte;
      end
      StPixHi: begin
        w_lcd_addr = 2'd1;
        w_lcd_byte = r_pixel[15:8];
      end
      StPixLo: begin
        w_lcd_addr = 2'd1;
        w_lcd_byte = r_pixel[7:0];
      end
      StCsHi: begin
        w_lcd_addr = 2'd2;
        w_lcd_byte = 8'h01;
      end
      default: w_is_byte = 1'b0;
    endcase
  end

  assign o_ready       = r_ready;
  assign o_rdata       = r_rdata;
  assign o_lcd_request = w_is_byte & ~r_rel;
  assign o_lcd_address = w_lcd_addr;
  assign o_lcd_wdata   = {24'h0, w_lcd_byte};
  assign o_pixel_ready = w_take;

endmodule
